// File: rtl/scan_dwell_timer.sv
// scan_dwell_timer: per-channel dwell sequencer counting P+1 cycles per step over N steps
//   i_clk, i_rst (async, active-high), i_start, i_period[15:0], i_steps[STEP_W-1:0],
//   i_hold, i_abort, [i_auto_reload when SCAN_TIMER_AUTO_RELOAD_EN is defined]
//   o_busy, o_count[15:0], o_step, o_step_idx[STEP_W-1:0], o_done, o_err
module scan_dwell_timer #(
   parameter int STEP_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [15:0]       i_period,
   input  logic [STEP_W-1:0] i_steps,
   input  logic              i_hold,
   input  logic              i_abort,
`ifdef SCAN_TIMER_AUTO_RELOAD_EN
   input  logic              i_auto_reload,
`endif
   output logic              o_busy,
   output logic [15:0]       o_count,
   output logic              o_step,
   output logic [STEP_W-1:0] o_step_idx,
   output logic              o_done,
   output logic              o_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [15:0] period, count_nxt, dec;
   logic [STEP_W-1:0] steps, idx_nxt;
   logic borrow, latch, step_nxt, done_nxt, err_nxt, last;
   minus_one u_dec (.i_a(o_count), .o_result(dec), .o_borrow(borrow));
   assign last = o_step_idx == steps - STEP_W'(1);
   assign o_busy = state != IDLE;
   always_comb begin
      state_nxt = state;
      count_nxt = o_count;
      idx_nxt = o_step_idx;
      latch = 1'b0;
      step_nxt = 1'b0;
      done_nxt = 1'b0;
      err_nxt = 1'b0;
      case (state)
         IDLE: if (i_start) begin
            if (i_steps != '0) begin
               latch = 1'b1;
               count_nxt = i_period;
               idx_nxt = '0;
               state_nxt = RUN;
            end else err_nxt = 1'b1;
         end
         RUN: if (i_abort) begin
            count_nxt = '0;
            idx_nxt = '0;
            state_nxt = IDLE;
         end else if (!i_hold) begin
            if (!borrow) count_nxt = dec;
            else begin
               step_nxt = 1'b1;
               if (!last) begin
                  count_nxt = period;
                  idx_nxt = o_step_idx + STEP_W'(1);
               end else begin
                  done_nxt = 1'b1;
`ifdef SCAN_TIMER_AUTO_RELOAD_EN
                  if (i_auto_reload) begin
                     count_nxt = period;
                     idx_nxt = '0;
                  end else state_nxt = DONE;
`else
                  state_nxt = DONE;
`endif
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         period <= '0;
         steps <= '0;
         o_count <= '0;
         o_step_idx <= '0;
         o_step <= 1'b0;
         o_done <= 1'b0;
         o_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            period <= i_period;
            steps <= i_steps;
         end
         o_count <= count_nxt;
         o_step_idx <= idx_nxt;
         o_step <= step_nxt;
         o_done <= done_nxt;
         o_err <= err_nxt;
      end
   end
endmodule

// minus_one: 16-bit prefix decrementer; bit g flips when every lower bit is zero
//   i_a[15:0] in, o_result[15:0] = i_a-1, o_borrow = (i_a == 0)
module minus_one (
   input  logic [15:0] i_a,
   output logic [15:0] o_result,
   output logic        o_borrow
);
   logic [16:0] z;
   assign z[0] = 1'b1;
   for (genvar g = 1; g <= 16; g++) begin : g_pfx
      assign z[g] = ~|i_a[g-1:0];
   end
   assign o_result = i_a ^ z[15:0];
   assign o_borrow = z[16];
endmodule

// File: tb/tb_scan_dwell_timer.sv
// tb_scan_dwell_timer: self-checking bench for scan_dwell_timer
module tb_scan_dwell_timer;
   localparam int SW = 8;
   logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_hold = 1'b0, i_abort = 1'b0;
   logic [15:0] i_period = '0;
   logic [SW-1:0] i_steps = '0;
   logic o_busy, o_step, o_done, o_err;
   logic [15:0] o_count;
   logic [SW-1:0] o_step_idx;
`ifdef SCAN_TIMER_AUTO_RELOAD_EN
   logic i_auto_reload = 1'b0;
`endif
   int total = 0, passed = 0;

   scan_dwell_timer #(.STEP_W(SW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_period(i_period),
      .i_steps(i_steps), .i_hold(i_hold), .i_abort(i_abort),
`ifdef SCAN_TIMER_AUTO_RELOAD_EN
      .i_auto_reload(i_auto_reload),
`endif
      .o_busy(o_busy), .o_count(o_count), .o_step(o_step),
      .o_step_idx(o_step_idx), .o_done(o_done), .o_err(o_err));

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference: u counts un-held RUN cycles since the start; step k spans
   // u in [k*(P+1), (k+1)*(P+1)), and the count reads P - u mod (P+1).
   task automatic run_seq(input logic [15:0] p, input int n, input int hold_at, input int hold_len,
                          input int abort_at, input bit hrand,
                          output int done_cyc, output int steps_seen, output int last_idx);
      longint len, u;
      int cyc, mode, idle_idx;
      bit step_pend, done_pend;
      len = longint'(p) + 1;
      u = 0;
      mode = 1;
      idle_idx = 0;
      step_pend = 0;
      done_pend = 0;
      done_cyc = 0;
      steps_seen = 0;
      i_period = p;
      i_steps = SW'(n);
      i_start = 1'b1;
      tick();
      cyc = 1;
      while (1) begin
         chk("busy", longint'(o_busy), longint'(mode != 0));
         chk("count", longint'(o_count), mode == 1 ? longint'(p) - u % len : 0);
         chk("step_idx", longint'(o_step_idx), mode == 1 ? u / len : mode == 2 ? n - 1 : idle_idx);
         chk("step", longint'(o_step), longint'(step_pend));
         chk("done", longint'(o_done), longint'(done_pend));
         chk("err", longint'(o_err), 0);
         if (o_done && done_cyc == 0) done_cyc = cyc;
         if (o_step) steps_seen++;
         last_idx = int'(o_step_idx);
         if (mode == 0) break;
         if (cyc > 70000) begin
            chk("timeout", cyc, 0);
            break;
         end
         i_hold = hrand ? ($urandom_range(0, 3) == 0) : (cyc >= hold_at && cyc < hold_at + hold_len);
         i_abort = (cyc == abort_at);
         i_start = 1'($urandom_range(0, 1));
         i_period = 16'($urandom);
         i_steps = SW'($urandom);
         step_pend = 0;
         done_pend = 0;
         if (mode == 2) begin
            mode = 0;
            idle_idx = n - 1;
         end else if (i_abort) begin
            mode = 0;
            idle_idx = 0;
         end else if (!i_hold) begin
            if (u % len == len - 1) step_pend = 1;
            if (u == longint'(n) * len - 1) begin
               done_pend = 1;
               mode = 2;
            end
            u++;
         end
         tick();
         cyc++;
      end
      i_start = 1'b0;
      i_hold = 1'b0;
      i_abort = 1'b0;
   endtask

   typedef struct {
      logic [15:0] p;
      int n, hold_at, hold_len, abort_at, exp_done, exp_steps, exp_idx;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int dc, ss, li;
      tbl[0] = '{16'd3, 2, -1, 0, -1, 9, 2, 1};
      tbl[1] = '{16'd0, 3, -1, 0, -1, 4, 3, 2};
      tbl[2] = '{16'd5, 2, 3, 4, -1, 17, 2, 1};
      tbl[3] = '{16'd10, 4, -1, 0, 3, 0, 0, 0};
      tbl[4] = '{16'hFFFF, 1, -1, 0, -1, 65537, 1, 0};
      tick();
      tick();
      chk("rst_busy", longint'(o_busy), 0);
      chk("rst_count", longint'(o_count), 0);
      chk("rst_idx", longint'(o_step_idx), 0);
      chk("rst_pulses", longint'({o_step, o_done, o_err}), 0);
      i_rst = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         run_seq(tbl[i].p, tbl[i].n, tbl[i].hold_at, tbl[i].hold_len, tbl[i].abort_at, 1'b0, dc, ss, li);
         chk($sformatf("vec%0d_done_cycle", i), dc, tbl[i].exp_done);
         chk($sformatf("vec%0d_steps", i), ss, tbl[i].exp_steps);
         chk($sformatf("vec%0d_idle_idx", i), li, tbl[i].exp_idx);
         if (i == 3) begin
            i_steps = '0;
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
            chk("err_pulse", longint'(o_err), 1);
            chk("err_busy", longint'(o_busy), 0);
            tick();
            chk("err_clear", longint'(o_err), 0);
            chk("err_busy2", longint'(o_busy), 0);
         end
      end
      for (int r = 0; r < 25; r++)
         run_seq(16'($urandom_range(0, 6)), $urandom_range(1, 4), -1, 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1, 1'b1, dc, ss, li);
      i_period = 16'd10;
      i_steps = SW'(2);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (13) tick();
      chk("pre_rst_busy", longint'(o_busy), 1);
      chk("pre_rst_idx", longint'(o_step_idx), 1);
      #2 i_rst = 1'b1;
      #1;
      chk("arst_busy", longint'(o_busy), 0);
      chk("arst_count", longint'(o_count), 0);
      chk("arst_idx", longint'(o_step_idx), 0);
      chk("arst_pulses", longint'({o_step, o_done, o_err}), 0);
      #2 i_rst = 1'b0;
      tick();
      chk("post_rst_busy", longint'(o_busy), 0);
      chk("post_rst_pulses", longint'({o_step, o_done}), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
